// File: rtl/melody_player.sv
// melody_player: steps a fixed song table and drives 4-bit note codes (15 = rest) to the tone generator.
// Optional build macro MELODY_GAP_EN: force a GAP_MS trailing rest at the end of every note.
module melody_player #(
    parameter int TICK_DIV = 1000,
    parameter int UNIT_MS  = 125,
    parameter int GAP_MS   = 10,
    parameter int SONG_LEN = 32
) (
    input  logic       RESET,
    input  logic       CLK_1M,
    input  logic       START,
    input  logic       STOP,
    input  logic       LOOP,
    output logic [3:0] NOTE,
    output logic       PLAYING,
    output logic [4:0] IDX,
    output logic       DONE
);
    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [15:0]   UNIT_LEN  = 16'(UNIT_MS);
    localparam logic [4:0]    IDX_LAST  = 5'(SONG_LEN - 1);
    localparam logic [3:0]    REST      = 4'd15;

    if (UNIT_MS < 1 || UNIT_MS > 4369 || GAP_MS >= UNIT_MS) begin : gParamCheck
        $error("melody_player: UNIT_MS must be 1..4369 and GAP_MS must be below UNIT_MS");
    end

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t        r_state, w_stateNext;
    logic          r_startQ;
    logic [TW-1:0] r_tickCnt, w_tickNext;
    logic [15:0]   r_msCnt, w_msNext;
    logic [3:0]    r_note, w_noteNext;
    logic [4:0]    r_idx, w_idxNext;
    logic          r_playing;
    logic          r_done, w_doneNext;
    logic          w_startEdge;
    logic          w_endSong;
    logic [7:0]    w_entry;
`ifdef MELODY_GAP_EN
    localparam logic [15:0] GAP_LEN = 16'(GAP_MS);
    logic [3:0]    r_pitch, w_pitchNext;
`endif

    // Song table entries are {note, dur}; dur = 0 marks the end of the song.
    function automatic logic [7:0] songEntry(input logic [4:0] idx);
        case (idx)
            5'd0, 5'd1: songEntry = 8'h72;
            5'd2, 5'd3: songEntry = 8'h92;
            5'd4, 5'd5: songEntry = 8'h72;
            5'd6:       songEntry = 8'h44;
            default:    songEntry = 8'h00;
        endcase
    endfunction

    assign w_startEdge = START & ~r_startQ;
    assign w_entry     = songEntry(r_idx);

    always_comb begin
        w_stateNext = r_state;
        w_tickNext  = r_tickCnt;
        w_msNext    = r_msCnt;
        w_noteNext  = r_note;
        w_idxNext   = r_idx;
        w_doneNext  = 1'b0;
        w_endSong   = 1'b0;
`ifdef MELODY_GAP_EN
        w_pitchNext = r_pitch;
`endif
        if (STOP) begin
            w_stateNext = IDLE;
            w_noteNext  = REST;
        end else begin
            case (r_state)
                IDLE: begin
                    w_noteNext = REST;
                    if (w_startEdge) begin
                        w_stateNext = LOAD;
                        w_idxNext   = 5'd0;
                    end
                end
                LOAD: begin
                    if (w_entry[3:0] != 4'd0) begin
                        w_noteNext  = w_entry[7:4];
                        w_msNext    = {12'd0, w_entry[3:0]} * UNIT_LEN;
                        w_tickNext  = '0;
                        w_stateNext = PLAY;
`ifdef MELODY_GAP_EN
                        w_pitchNext = w_entry[7:4];
`endif
                    end else begin
                        w_endSong = 1'b1;
                    end
                end
                PLAY: begin
                    if (r_tickCnt == TICK_LAST) begin
                        w_tickNext = '0;
                        w_msNext   = r_msCnt - 16'd1;
                        if (r_msCnt == 16'd1) begin
                            if (r_idx == IDX_LAST) begin
                                w_endSong = 1'b1;
                            end else begin
                                w_idxNext   = r_idx + 5'd1;
                                w_stateNext = LOAD;
                            end
                        end
                    end else begin
                        w_tickNext = r_tickCnt + TW'(1);
                    end
`ifdef MELODY_GAP_EN
                    w_noteNext = (w_msNext <= GAP_LEN) ? REST : r_pitch;
`endif
                end
                default: w_stateNext = IDLE;
            endcase

            // NOTE is left alone when looping so the last pitch bridges the restart.
            if (w_endSong) begin
                if (LOOP) begin
                    w_idxNext   = 5'd0;
                    w_stateNext = LOAD;
                end else begin
                    w_doneNext  = 1'b1;
                    w_noteNext  = REST;
                    w_stateNext = IDLE;
                end
            end
        end
    end

    always_ff @(posedge CLK_1M or negedge RESET) begin
        if (!RESET) begin
            r_state   <= IDLE;
            r_startQ  <= 1'b0;
            r_tickCnt <= '0;
            r_msCnt   <= '0;
            r_note    <= REST;
            r_idx     <= 5'd0;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
`ifdef MELODY_GAP_EN
            r_pitch   <= REST;
`endif
        end else begin
            r_state   <= w_stateNext;
            r_startQ  <= START;
            r_tickCnt <= w_tickNext;
            r_msCnt   <= w_msNext;
            r_note    <= w_noteNext;
            r_idx     <= w_idxNext;
            r_playing <= (w_stateNext != IDLE);
            r_done    <= w_doneNext;
`ifdef MELODY_GAP_EN
            r_pitch   <= w_pitchNext;
`endif
        end
    end

    assign NOTE    = r_note;
    assign PLAYING = r_playing;
    assign IDX     = r_idx;
    assign DONE    = r_done;

endmodule
